// File: rtl/poly_pipe_array_rst_tree.sv
// Array of independent cubic-polynomial pipelines, f(x) = C3*x^3 + C2*x^2 + C1*x + C0,
// with shared valid/stall control and a registered reset/clear distribution tree.
module poly_pipe_array_rst_tree #(
  parameter int WIDTH        = 8,
  parameter int NUM_CHANNELS = 8,
  parameter int RST_FANOUT   = 2,
  parameter logic [4*WIDTH-1:0] C3 = (4*WIDTH)'(10),
  parameter logic [4*WIDTH-1:0] C2 = (4*WIDTH)'(20),
  parameter logic [4*WIDTH-1:0] C1 = (4*WIDTH)'(30),
  parameter logic [4*WIDTH-1:0] C0 = (4*WIDTH)'(40)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_clr,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     in  [NUM_CHANNELS],
  output logic [4*WIDTH-1:0]   out [NUM_CHANNELS],
  output logic                 valid_out,
  output logic                 ready,
  output logic                 drop_err
);

  localparam int W4 = 4 * WIDTH;

  function automatic int calc_levels(input int n, input int f);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * f;
      l++;
    end
    return l;
  endfunction

  // Registers at level j: min(RST_FANOUT^j, NUM_CHANNELS), clamped as we go to avoid overflow.
  function automatic int level_size(input int j);
    int p;
    p = 1;
    for (int i = 0; i < j; i++) begin
      p = p * RST_FANOUT;
      if (p > NUM_CHANNELS) p = NUM_CHANNELS;
    end
    return (p > NUM_CHANNELS) ? NUM_CHANNELS : p;
  endfunction

  function automatic int level_offset(input int j);
    int s;
    s = 0;
    for (int i = 0; i < j; i++) s = s + level_size(i);
    return s;
  endfunction

  localparam int L           = calc_levels(NUM_CHANNELS, RST_FANOUT);
  localparam int RST_LATENCY = L + 1;
  localparam int TREE_BITS   = level_offset(L + 1);
  localparam int LEAF_BASE   = level_offset(L);
  localparam int CNT_W       = $clog2(RST_LATENCY + 1);

  logic [TREE_BITS-1:0] tree;

  (* dont_merge *) logic root_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) root_q <= 1'b1;
    else     root_q <= soft_clr;
  end

  assign tree[0] = root_q;

  for (genvar j = 1; j <= L; j++) begin : g_level
    for (genvar k = 0; k < level_size(j); k++) begin : g_node
      (* dont_merge *) logic q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b1;
        else     q <= tree[level_offset(j-1) + k / RST_FANOUT];
      end

      assign tree[level_offset(j) + k] = q;
    end
  end

  // Each channel clears on its own leaf; the clear wins over an en-gated load.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic          leaf;
    logic [W4-1:0] xe;
    logic [W4-1:0] x1, xsq1, c1x1;
    logic [W4-1:0] xcu2, c2x2, lin2;
    logic [W4-1:0] c3x3, sum3;
    logic [W4-1:0] out_q;

    assign leaf = tree[LEAF_BASE + i];
    assign xe   = W4'(in[i]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst || leaf) begin
        x1    <= '0;
        xsq1  <= '0;
        c1x1  <= '0;
        xcu2  <= '0;
        c2x2  <= '0;
        lin2  <= '0;
        c3x3  <= '0;
        sum3  <= '0;
        out_q <= '0;
      end else if (en) begin
        x1    <= xe;
        xsq1  <= xe * xe;
        c1x1  <= C1 * xe;
        xcu2  <= xsq1 * x1;
        c2x2  <= C2 * xsq1;
        lin2  <= c1x1 + C0;
        c3x3  <= C3 * xcu2;
        sum3  <= c2x2 + lin2;
        out_q <= c3x3 + sum3;
      end
    end

    assign out[i] = out_q;
  end

  logic [3:0] vpipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vpipe <= '0;
    else if (soft_clr) vpipe <= '0;
    else if (en)       vpipe <= {vpipe[2:0], valid_in & ready};
  end

  assign valid_out = vpipe[3];

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= CNT_W'(RST_LATENCY);
    else if (soft_clr)     cnt <= CNT_W'(RST_LATENCY);
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  // The counter tracks tree depth, so it reaches zero exactly when the tree has drained;
  // gating on an idle tree as well makes that dependency explicit.
  assign ready = (cnt == '0) && !(|tree);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_err <= 1'b0;
    else if (valid_in && en && !ready) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_poly_pipe_array_rst_tree.sv
// Directed bench for poly_pipe_array_rst_tree: reset release, single samples,
// stalled streaming, soft clear, async reset, and two alternative tree shapes.
module tb_poly_pipe_array_rst_tree;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_clr = 1'b0;
  logic        en = 1'b1;
  logic        valid_in = 1'b0;
  logic        valid_in_s = 1'b0;

  logic [7:0]  in_a [8];
  logic [31:0] out_a [8];
  logic        valid_out, ready, drop_err;

  logic [7:0]  in_b [5];
  logic [31:0] out_b [5];
  logic        valid_out_b, ready_b, drop_err_b;

  logic [7:0]  in_c [1];
  logic [31:0] out_c [1];
  logic        valid_out_c, ready_c, drop_err_c;

  int tests_run = 0;
  int tests_failed = 0;

  logic       model_v [4];
  logic [7:0] model_x [4];
  logic [7:0] next_x;

  always #5 clk = ~clk;

  poly_pipe_array_rst_tree dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .en(en), .valid_in(valid_in),
    .in(in_a), .out(out_a), .valid_out(valid_out), .ready(ready), .drop_err(drop_err)
  );

  poly_pipe_array_rst_tree #(.NUM_CHANNELS(5), .RST_FANOUT(3)) dut_b (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .en(en), .valid_in(valid_in_s),
    .in(in_b), .out(out_b), .valid_out(valid_out_b), .ready(ready_b), .drop_err(drop_err_b)
  );

  poly_pipe_array_rst_tree #(.NUM_CHANNELS(1)) dut_c (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .en(en), .valid_in(valid_in_s),
    .in(in_c), .out(out_c), .valid_out(valid_out_c), .ready(ready_c), .drop_err(drop_err_c)
  );

  function automatic logic [31:0] poly(input logic [31:0] x);
    return 32'd10 * x * x * x + 32'd20 * x * x + 32'd30 * x + 32'd40;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] x, input logic spread);
    valid_in = v;
    for (int i = 0; i < 8; i++) in_a[i] = spread ? x + 8'(i) : x;
  endtask

  task automatic checkAllChannels(input string tag, input logic [31:0] expected);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("%s ch%0d", tag, i), out_a[i], expected);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  vec_x [3];
    logic [31:0] vec_f [3];
    vec_x[0] = 8'd2;   vec_f[0] = 32'd260;
    vec_x[1] = 8'd0;   vec_f[1] = 32'd40;
    vec_x[2] = 8'd255; vec_f[2] = 32'd167121940;

    applyStimulus(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) in_b[i] = 8'd0;
    in_c[0] = 8'd0;

    repeat (2) tick();
    checkOutput("reset ready", ready, 0);
    checkOutput("reset valid_out", valid_out, 0);
    checkOutput("reset drop_err", drop_err, 0);
    checkOutput("reset out0", out_a[0], 0);
    checkOutput("reset out7", out_a[7], 0);
    checkOutput("reset ready_b", ready_b, 0);
    checkOutput("reset ready_c", ready_c, 0);

    // Offer a sample on the first edge after release; it must be dropped.
    rst = 1'b0;
    valid_in = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) valid_in = 1'b0;
      checkOutput($sformatf("release ready edge%0d", e), ready, (e >= 4));
      checkOutput($sformatf("release ready_b edge%0d", e), ready_b, (e >= 3));
      checkOutput($sformatf("release ready_c edge%0d", e), ready_c, (e >= 1));
    end
    checkOutput("drop_err after early offer", drop_err, 1);
    repeat (4) begin
      tick();
      checkOutput("no valid from dropped sample", valid_out, 0);
    end

    for (int t = 0; t < 3; t++) begin
      applyStimulus(1'b1, vec_x[t], 1'b0);
      if (t == 0) begin
        valid_in_s = 1'b1;
        for (int i = 0; i < 5; i++) in_b[i] = 8'd3 + 8'(i);
        in_c[0] = 8'd3;
      end
      tick();
      applyStimulus(1'b0, vec_x[t], 1'b0);
      valid_in_s = 1'b0;
      repeat (2) tick();
      checkOutput($sformatf("single x=%0d valid early", vec_x[t]), valid_out, 0);
      tick();
      checkOutput($sformatf("single x=%0d valid", vec_x[t]), valid_out, 1);
      checkAllChannels($sformatf("single x=%0d out", vec_x[t]), vec_f[t]);
      if (t == 0) begin
        checkOutput("dut_b valid", valid_out_b, 1);
        checkOutput("dut_b ch0 x=3", out_b[0], 32'd580);
        for (int i = 1; i < 5; i++)
          checkOutput($sformatf("dut_b ch%0d", i), out_b[i], poly(32'd3 + 32'(i)));
        checkOutput("dut_c valid", valid_out_c, 1);
        checkOutput("dut_c ch0 x=3", out_c[0], 32'd580);
      end
      tick();
      checkOutput($sformatf("single x=%0d valid one cycle", vec_x[t]), valid_out, 0);
    end

    // Streaming with en toggling; a held sample is only taken on en=1 edges.
    for (int k = 0; k < 4; k++) begin
      model_v[k] = 1'b0;
      model_x[k] = 8'd0;
    end
    next_x = 8'd0;
    for (int c = 0; c < 24; c++) begin
      en = (c % 2 == 0);
      if (c < 12) applyStimulus(1'b1, next_x, 1'b1);
      else        valid_in = 1'b0;
      tick();
      if (en) begin
        for (int k = 3; k > 0; k--) begin
          model_v[k] = model_v[k-1];
          model_x[k] = model_x[k-1];
        end
        model_v[0] = valid_in;
        model_x[0] = next_x;
        if (valid_in) next_x = next_x + 8'd1;
      end
      checkOutput($sformatf("stream c%0d valid", c), valid_out, model_v[3]);
      if (model_v[3])
        for (int i = 0; i < 8; i++)
          checkOutput($sformatf("stream c%0d ch%0d", c, i), out_a[i], poly(32'(model_x[3]) + 32'(i)));
    end
    en = 1'b1;
    valid_in = 1'b0;
    checkOutput("stream count", 32'(next_x), 6);

    // Three samples in flight, then a one-cycle soft clear.
    applyStimulus(1'b1, 8'd7, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd8, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd9, 1'b1);
    tick();
    valid_in = 1'b0;
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    checkOutput("clr T0 ready", ready, 0);
    checkOutput("clr T0 valid", valid_out, 0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput($sformatf("clr T0+%0d valid", e), valid_out, 0);
      checkOutput($sformatf("clr T0+%0d ready", e), ready, (e >= 4));
      if (e == 2) begin
        checkOutput("clr T0+2 out ch0 not yet cleared", out_a[0], poly(32'd9));
        checkOutput("clr T0+2 out ch7 not yet cleared", out_a[7], poly(32'd16));
      end
      if (e == 4) checkAllChannels("clr T0+4 out", 0);
    end
    checkOutput("clr drop_err kept", drop_err, 1);

    // Asynchronous reset in the middle of a cycle with valid data at the output.
    applyStimulus(1'b1, 8'd2, 1'b0);
    tick();
    valid_in = 1'b0;
    repeat (3) tick();
    checkOutput("pre-rst valid", valid_out, 1);
    checkOutput("pre-rst out3", out_a[3], 32'd260);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst out0", out_a[0], 0);
    checkOutput("async rst out7", out_a[7], 0);
    checkOutput("async rst valid", valid_out, 0);
    checkOutput("async rst ready", ready, 0);
    checkOutput("async rst drop_err", drop_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/poly_pipe_array_rst_tree.md
# poly_pipe_array_rst_tree

Parametrised array of NUM_CHANNELS independent cubic-polynomial pipelines, f(x) = C3·x³ + C2·x² + C1·x + C0, sharing one valid/stall control. Reset reaches the channels through a generic reset register tree of arbitrary fanout and depth. The block also supports a synchronous soft clear routed through the same tree. A `ready` output exposes the reset/clear latency so upstream logic never issues into a partially reset array. It replaces the fixed 8-channel, hard-wired-tree replicated pipeline in timing experiments and throughput datapaths.

## Interface
- WIDTH, 8: input sample width; result width is 4·WIDTH.
- NUM_CHANNELS, 8: number of replicated pipelines, ≥1.
- RST_FANOUT, 2: tree branching factor, ≥2.
- C3, C2, C1, C0, defaults 10, 20, 30, 40: coefficients, each 4·WIDTH bits unsigned.
- Derived: L = smallest integer with RST_FANOUT^L ≥ NUM_CHANNELS (L=0 when NUM_CHANNELS=1); RST_LATENCY = L+1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- soft_clr  in  1  synchronous clear request, sampled on clk.
- en  in  1  global advance; 0 stalls every data and valid stage.
- valid_in  in  1  input samples valid.
- in[NUM_CHANNELS]  in  WIDTH each  per-channel x, unsigned.
- out[NUM_CHANNELS]  out  4·WIDTH each  per-channel f(x).
- valid_out  out  1  out valid.
- ready  out  1  array accepts input.
- drop_err  out  1  sticky: a sample was offered while ready=0.

## Operation
- Tree structure:
  - Level 0 is a single root register fed by soft_clr.
  - Level j holds min(RST_FANOUT^j, NUM_CHANNELS) registers. Register k at level j drives level j+1 indices k·RST_FANOUT … k·RST_FANOUT+RST_FANOUT−1, truncated at the level size.
  - Level L register i is the leaf reset for channel i.
  - All tree registers carry dont_merge and are never gated by en.
- rst behaviour:
  - rst asynchronously presets every tree register to 1, so leaves and channel registers clear immediately.
  - After rst deasserts, 0 ripples down one level per clock.
- soft_clr behaviour: soft_clr=1 propagates to the leaves one level per clock. A leaf at 1 synchronously clears its channel's data registers, including out. This clear is not gated by en.
- Arithmetic:
  - x is zero-extended to 4·WIDTH.
  - Every product and sum is truncated modulo 2^(4·WIDTH).
  - The result equals f(x) mod 2^(4·WIDTH).
- Pipeline stages, all advancing only when en=1:
  - S1: x², C1·x.
  - S2: x³, C2·x², C1·x+C0.
  - S3: C3·x³, C2·x²+C1·x+C0.
  - S4: out.
- Valid path:
  - 4-deep shift register, shifting when en=1.
  - Stage 0 loads (valid_in & ready).
  - The valid path is asynchronously cleared by rst directly and synchronously cleared by soft_clr directly, with no tree latency. valid_out may never be high for stale data.
- Ready counter:
  - rst loads RST_LATENCY.
  - An edge with soft_clr=1 loads RST_LATENCY. Reloading during an in-flight clear extends it.
  - Otherwise the counter decrements each cycle while nonzero; ready = (cnt==0).
- drop_err is set on any edge with valid_in=1, en=1, ready=0. Only rst clears it; soft_clr does not.

## Timing
- Reset values: out=0 on all channels, valid_out=0, ready=0, drop_err=0, all tree registers=1.
- Latency: valid_out rises 4 en=1 edges after an accepted sample. Throughput is 1 sample per en=1 cycle.
- en=0 holds out and valid_out unchanged.
- After rst deasserts, leaves fall after edge RST_LATENCY. ready rises after that same edge, so the first accepted input is captured on edge RST_LATENCY+1.
- soft_clr sampled at edge T0:
  - valid stages read 0 after T0.
  - Leaves are high during the cycle after edge T0+L.
  - Channel data clears at edge T0+RST_LATENCY.
  - ready is low for exactly RST_LATENCY cycles after T0 and high after edge T0+RST_LATENCY.
- Simultaneous clear and load: a data load coinciding with a leaf clear loses to the clear. This cannot occur for accepted samples because ready=0 throughout.
- rst mid-operation clears everything immediately regardless of en or soft_clr.

## Test plan
- Defaults, pulse rst, hold en=1 → ready=0 for 4 edges after deassert and 1 after the 4th. valid_in=1 offered before then sets drop_err=1, and valid_out stays 0.
- Defaults, in[i]=2 on all channels, one valid_in cycle after ready → 4 edges later valid_out=1 for one cycle, out[i]=260 on all channels. Same test with in=0 → out=40. With in=255 → out=167121940.
- Streaming in=0,1,2,… with en toggling 1,0,1,… → out matches f(x) in order, and valid_out never advances on en=0 cycles.
- soft_clr pulse while 3 samples are in flight → valid_out never rises for them. ready is low for 4 cycles, out is 0 after edge T0+4, and drop_err is unchanged.
- NUM_CHANNELS=5, RST_FANOUT=3 (L=2) and NUM_CHANNELS=1 (L=0) → ready low 3 and 1 cycles respectively after rst release. All channel leaves deassert on the same edge.
- rst asserted mid-stream between edges → out, valid_out, ready and drop_err read 0 before the next clk edge.
